// File: rtl/conv_rd_addr_gen.sv
// Read-address generator for the convolution datapath: walks the IF and filter
// scratchpads one window at a time and reports window/run completion.
module conv_rd_addr_gen #(
  parameter int IF_ADDR_LEN   = 4,
  parameter int FILT_ADDR_LEN = 4,
  parameter int WIN_CNT_LEN   = 6
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     start_rd_gen,
  input  logic                     stall,
  input  logic [IF_ADDR_LEN-1:0]   base_addr,
  input  logic [FILT_ADDR_LEN-1:0] filt_size,
  input  logic [IF_ADDR_LEN-1:0]   stride,
  input  logic [WIN_CNT_LEN-1:0]   num_windows,
  output logic [IF_ADDR_LEN-1:0]   if_rd_addr,
  output logic [FILT_ADDR_LEN-1:0] filt_rd_addr,
  output logic                     rd_en,
  output logic                     psum_done,
  output logic                     stride_count_flag,
  output logic                     full_done,
  output logic                     busy,
  output logic [1:0]               state_dbg
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_READ = 2'd1,
    S_EMIT = 2'd2,
    S_FIN  = 2'd3
  } state_t;

  state_t                   state;
  logic [IF_ADDR_LEN-1:0]   base;
  logic [FILT_ADDR_LEN-1:0] tap;
  logic [WIN_CNT_LEN-1:0]   win;
  logic [FILT_ADDR_LEN-1:0] filt_q;
  logic [IF_ADDR_LEN-1:0]   stride_q;
  logic [WIN_CNT_LEN-1:0]   nwin_q;

  logic [IF_ADDR_LEN:0]     base_sum;
  logic                     last_tap;
  logic                     last_win;

  assign base_sum = {1'b0, base} + {1'b0, stride_q};
  assign last_tap = (tap == filt_q - FILT_ADDR_LEN'(1));
  assign last_win = (win == nwin_q - WIN_CNT_LEN'(1));

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= S_IDLE;
      base     <= '0;
      tap      <= '0;
      win      <= '0;
      filt_q   <= '0;
      stride_q <= '0;
      nwin_q   <= '0;
    end else if (start_rd_gen) begin
      // Start doubles as restart: any in-flight window is dropped here.
      filt_q   <= filt_size;
      stride_q <= stride;
      nwin_q   <= num_windows;
      base     <= base_addr;
      tap      <= '0;
      win      <= '0;
      state    <= (filt_size == '0 || num_windows == '0) ? S_FIN : S_READ;
    end else begin
      case (state)
        S_READ: begin
          if (!stall) begin
            if (last_tap) begin
              state <= last_win ? S_FIN : S_EMIT;
            end else begin
              tap <= tap + FILT_ADDR_LEN'(1);
            end
          end
        end
        S_EMIT: begin
          base  <= base_sum[IF_ADDR_LEN-1:0];
          tap   <= '0;
          win   <= win + WIN_CNT_LEN'(1);
          state <= S_READ;
        end
        S_FIN:   state <= S_IDLE;
        default: state <= S_IDLE;
      endcase
    end
  end

  // Handshake: rd_en is the valid for the address pair and !stall is the
  // consumer's ready; an address is consumed only in a cycle with
  // rd_en=1, and while stalled the address pair holds unchanged.
  assign rd_en             = (state == S_READ) && !stall;
  assign if_rd_addr        = base + IF_ADDR_LEN'(tap);
  assign filt_rd_addr      = tap;
  assign psum_done         = (state == S_EMIT);
  assign stride_count_flag = (state == S_EMIT) && base_sum[IF_ADDR_LEN];
  assign full_done         = (state == S_FIN);
  assign busy              = (state == S_READ) || (state == S_EMIT);
  assign state_dbg         = state;

  a_done_exclusive: assert property (@(posedge clk) !(psum_done && full_done));
  a_flag_with_psum: assert property (@(posedge clk) stride_count_flag |-> psum_done);

endmodule

// File: tb/tb_conv_rd_addr_gen.sv
// Randomised scoreboard bench for conv_rd_addr_gen: a per-cycle expected trace
// is built from the window/tap rules and compared by an independent monitor.
module tb_conv_rd_addr_gen;

  localparam int IFL = 4;
  localparam int FL  = 4;
  localparam int WL  = 6;
  localparam int IF_DEPTH = 1 << IFL;

  logic           clk;
  logic           rst;
  logic           start_rd_gen;
  logic           stall;
  logic [IFL-1:0] base_addr;
  logic [FL-1:0]  filt_size;
  logic [IFL-1:0] stride;
  logic [WL-1:0]  num_windows;
  logic [IFL-1:0] if_rd_addr;
  logic [FL-1:0]  filt_rd_addr;
  logic           rd_en;
  logic           psum_done;
  logic           stride_count_flag;
  logic           full_done;
  logic           busy;
  logic [1:0]     state_dbg;

  conv_rd_addr_gen #(.IF_ADDR_LEN(IFL), .FILT_ADDR_LEN(FL), .WIN_CNT_LEN(WL)) dut (
    .clk(clk), .rst(rst), .start_rd_gen(start_rd_gen), .stall(stall),
    .base_addr(base_addr), .filt_size(filt_size), .stride(stride),
    .num_windows(num_windows), .if_rd_addr(if_rd_addr), .filt_rd_addr(filt_rd_addr),
    .rd_en(rd_en), .psum_done(psum_done), .stride_count_flag(stride_count_flag),
    .full_done(full_done), .busy(busy), .state_dbg(state_dbg)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Record: {chk_addr, rd_en, psum, scf, full, busy, if_addr[3:0], filt_addr[3:0]}
  logic [13:0] exp_q[$];
  logic [13:0] run_q[$];
  bit          stall_arr[256];
  int          total = 0;
  int          bad   = 0;
  int          cyc   = 0;

  function automatic logic [13:0] mk(bit chk, bit rd, bit ps, bit sc, bit fu, bit bu,
                                     int ia, int fa);
    logic [13:0] r;
    r = {chk, rd, ps, sc, fu, bu, 4'(ia), 4'(fa)};
    return r;
  endfunction

  // Reference model: nested window/tap loops producing one record per cycle.
  task automatic build_model(input int b0, input int fs, input int sd, input int nw);
    int c;
    int b;
    c = 0;
    b = b0;
    run_q.delete();
    if (fs == 0 || nw == 0) begin
      run_q.push_back(mk(0, 0, 0, 0, 1, 0, 0, 0));
      return;
    end
    for (int w = 0; w < nw; w++) begin
      for (int t = 0; t < fs; t++) begin
        while (stall_arr[c]) begin
          run_q.push_back(mk(1, 0, 0, 0, 0, 1, (b + t) % IF_DEPTH, t));
          c++;
        end
        run_q.push_back(mk(1, 1, 0, 0, 0, 1, (b + t) % IF_DEPTH, t));
        c++;
      end
      if (w == nw - 1) begin
        run_q.push_back(mk(0, 0, 0, 0, 1, 0, 0, 0));
      end else begin
        run_q.push_back(mk(0, 0, 1, (b + sd) >= IF_DEPTH, 0, 1, 0, 0));
        b = (b + sd) % IF_DEPTH;
      end
      c++;
    end
  endtask

  // Called at posedge+1; returns at posedge+1 of the last cycle driven.
  task automatic start_run(input int b0, input int fs, input int sd, input int nw,
                           input int limit);
    int n;
    base_addr    = IFL'(b0);
    filt_size    = FL'(fs);
    stride       = IFL'(sd);
    num_windows  = WL'(nw);
    start_rd_gen = 1'b1;
    @(posedge clk);
    #1;
    start_rd_gen = 1'b0;
    build_model(b0, fs, sd, nw);
    n = (limit > 0 && limit < run_q.size()) ? limit : run_q.size();
    for (int i = 0; i < n; i++) exp_q.push_back(run_q[i]);
    for (int c = 0; c < n; c++) begin
      stall = stall_arr[c];
      if (c < n - 1) begin
        @(posedge clk);
        #1;
      end
    end
  endtask

  task automatic idle_cycles(input int m);
    for (int i = 0; i < m; i++) begin
      @(posedge clk);
      #1;
      stall = 1'($urandom_range(0, 1));
      exp_q.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0));
    end
    stall = 1'b0;
  endtask

  task automatic clear_stalls();
    for (int i = 0; i < 256; i++) stall_arr[i] = 1'b0;
  endtask

  task automatic check_idle_state(input string name);
    @(negedge clk);
    total++;
    if (state_dbg != 2'd0) begin
      bad++;
      $display("FAIL %s state got=%0d exp=0", name, state_dbg);
    end
  endtask

  // Monitor: one expected record per cycle, sampled mid-cycle.
  initial begin
    logic [13:0] e;
    forever begin
      @(negedge clk);
      cyc++;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        total++;
        if ({rd_en, psum_done, stride_count_flag, full_done, busy} !== e[12:8]) begin
          bad++;
          $display("FAIL strobes cyc=%0d got=%b exp=%b (rd,psum,scf,full,busy)", cyc,
                   {rd_en, psum_done, stride_count_flag, full_done, busy}, e[12:8]);
        end
        if (e[13]) begin
          total++;
          if ({if_rd_addr, filt_rd_addr} !== e[7:0]) begin
            bad++;
            $display("FAIL addr cyc=%0d got if=%0d filt=%0d exp if=%0d filt=%0d", cyc,
                     if_rd_addr, filt_rd_addr, e[7:4], e[3:0]);
          end
        end
      end
    end
  end

  initial begin
    int waited;
    rst = 1'b1; start_rd_gen = 1'b0; stall = 1'b0;
    base_addr = '0; filt_size = '0; stride = '0; num_windows = '0;
    clear_stalls();

    // Reset state
    @(posedge clk);
    #1;
    exp_q.push_back(mk(1, 0, 0, 0, 0, 0, 0, 0));
    check_idle_state("reset");
    @(posedge clk);
    #1;
    rst = 1'b0;
    exp_q.push_back(mk(1, 0, 0, 0, 0, 0, 0, 0));
    idle_cycles(1);

    // Basic run
    clear_stalls();
    @(posedge clk); #1;
    start_run(0, 3, 1, 2, 0);
    idle_cycles(2);

    // Wrap around the IF scratchpad
    clear_stalls();
    @(posedge clk); #1;
    start_run(14, 3, 2, 2, 0);
    idle_cycles(2);

    // Stall for 2 cycles at tap 1 of window 0
    clear_stalls();
    stall_arr[1] = 1'b1;
    stall_arr[2] = 1'b1;
    @(posedge clk); #1;
    start_run(0, 3, 1, 2, 0);
    idle_cycles(2);

    // Degenerate configurations
    clear_stalls();
    @(posedge clk); #1;
    start_run(3, 0, 1, 5, 0);
    idle_cycles(2);
    @(posedge clk); #1;
    start_run(3, 2, 1, 0, 0);
    idle_cycles(2);

    // Restart during tap 2 of window 1, then reset (with start) in READ
    clear_stalls();
    @(posedge clk); #1;
    start_run(2, 3, 3, 4, 7);
    start_run(8, 3, 1, 4, 2);
    rst = 1'b1;
    start_rd_gen = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    start_rd_gen = 1'b0;
    exp_q.push_back(mk(1, 0, 0, 0, 0, 0, 0, 0));
    check_idle_state("rst_in_read");
    idle_cycles(2);

    // Randomised runs
    for (int r = 0; r < 25; r++) begin
      clear_stalls();
      for (int i = 0; i < 150; i++) stall_arr[i] = ($urandom_range(0, 3) == 0);
      @(posedge clk); #1;
      start_run($urandom_range(0, 15), $urandom_range(0, 5), $urandom_range(0, 15),
                $urandom_range(0, 4), 0);
      idle_cycles($urandom_range(1, 3));
    end

    waited = 0;
    while (exp_q.size() > 0 && waited < 200) begin
      @(posedge clk);
      waited++;
    end
    if (exp_q.size() > 0) begin
      total++;
      bad++;
      $display("FAIL drain left=%0d exp=0", exp_q.size());
    end
    @(posedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
